// File: rtl/mips_pipe_pkg.sv
// Shared types and defaults for the split-MEM pipeline hazard/forwarding logic.
package mips_pipe_pkg;

    localparam int DEPTH_DEF   = 4;
    localparam int ALU_RDY_DEF = 1;
    localparam int LD_RDY_DEF  = 3;
    // Track entries carry rd at this fixed width; narrower register files zero-extend.
    localparam int REG_AW_MAX  = 8;
    // Forward-select value meaning "use the register file operand".
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  load;
    } track_entry_t;

    // First track index at which a producer's result can be forwarded.
    function automatic int rdy_of(input logic load, input int alu_rdy, input int ld_rdy);
        return load ? ld_rdy : alu_rdy;
    endfunction

endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// ID-stage request / hazard-response bundle between the decode stage and the scoreboard.
interface pipe_hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wr;
    logic [REG_AW-1:0] id_rd;
    logic              id_load;
    logic              flush;
    logic              stall;
    logic [SEL_W-1:0]  ex_fwd_a;
    logic [SEL_W-1:0]  ex_fwd_b;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_rd, id_load, flush,
        input  stall, ex_fwd_a, ex_fwd_b, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_rd, id_load, flush,
        output stall, ex_fwd_a, ex_fwd_b, stall_cnt
    );
endinterface

// File: rtl/hazard_match_prio.sv
// Youngest-first search of the in-flight producer track for one source register.
module hazard_match_prio
    import mips_pipe_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int REG_AW  = 5,
    parameter int ALU_RDY = ALU_RDY_DEF,
    parameter int LD_RDY  = LD_RDY_DEF,
    parameter int SEL_W   = $clog2(DEPTH)
) (
    input  track_entry_t      track [DEPTH],
    input  logic [REG_AW-1:0] reg_addr,
    output logic              hit,
    output logic [SEL_W-1:0]  idx,
    output logic              ready
);

    logic [DEPTH-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            // r0 is hard-wired, so it never depends on an in-flight producer.
            assign match[gi] = track[gi].valid
                            && (track[gi].rd == REG_AW_MAX'(reg_addr))
                            && (reg_addr != '0);
        end
    endgenerate

    // Scan oldest to youngest so the youngest matching producer is the one that sticks.
    // A producer in the last slot has already written back, so it is always ready.
    always_comb begin
        hit   = 1'b0;
        idx   = '0;
        ready = 1'b1;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit   = 1'b1;
                idx   = SEL_W'(k);
                ready = (k == DEPTH - 1) || ((k + 1) >= rdy_of(track[k].load, ALU_RDY, LD_RDY));
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// Issue/stall decision in ID and registered EX forward selects from a producer tag shift register.
module pipe_hazard_scoreboard
    import mips_pipe_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int REG_AW  = 5,
    parameter int ALU_RDY = ALU_RDY_DEF,
    parameter int LD_RDY  = LD_RDY_DEF,
    parameter int CNT_W   = 16
) (
    input logic                    clk,
    input logic                    reset,
    pipe_hazard_scoreboard_if.slave bus
);

    localparam int SEL_W = $clog2(DEPTH);

    track_entry_t     track_reg [DEPTH];
    track_entry_t     entry_next;
    logic             hit_rs, hit_rt, rdy_rs, rdy_rt;
    logic [SEL_W-1:0] idx_rs, idx_rt;
    logic             hazard_rs, hazard_rt, stall, issue;
    logic [SEL_W-1:0] fwd_a_next, fwd_b_next, fwd_a_reg, fwd_b_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    hazard_match_prio #(
        .DEPTH(DEPTH), .REG_AW(REG_AW), .ALU_RDY(ALU_RDY), .LD_RDY(LD_RDY), .SEL_W(SEL_W)
    ) u_match_rs (
        .track(track_reg), .reg_addr(bus.id_rs), .hit(hit_rs), .idx(idx_rs), .ready(rdy_rs)
    );

    hazard_match_prio #(
        .DEPTH(DEPTH), .REG_AW(REG_AW), .ALU_RDY(ALU_RDY), .LD_RDY(LD_RDY), .SEL_W(SEL_W)
    ) u_match_rt (
        .track(track_reg), .reg_addr(bus.id_rt), .hit(hit_rt), .idx(idx_rt), .ready(rdy_rt)
    );

    // Stall only for operands actually read; a flushed instruction never stalls.
    always_comb begin
        hazard_rs = hit_rs & ~rdy_rs;
        hazard_rt = hit_rt & ~rdy_rt;
        stall     = bus.id_valid & ~bus.flush
                  & ((hazard_rs & bus.id_use_rs) | (hazard_rt & bus.id_use_rt));
        issue     = bus.id_valid & ~bus.flush & ~stall;

        // Non-writers and r0 writers enter the track as bubbles.
        entry_next.valid = issue & bus.id_wr & (bus.id_rd != '0);
        entry_next.rd    = REG_AW_MAX'(bus.id_rd);
        entry_next.load  = bus.id_load;

        // The producer advances one slot as the consumer enters EX, hence idx+1.
        // A producer leaving the last slot is covered by the register-file bypass.
        fwd_a_next = SEL_W'(FWD_REGFILE);
        fwd_b_next = SEL_W'(FWD_REGFILE);
        if (issue && hit_rs && (idx_rs != SEL_W'(DEPTH - 1))) begin
            fwd_a_next = idx_rs + SEL_W'(1);
        end
        if (issue && hit_rt && (idx_rt != SEL_W'(DEPTH - 1))) begin
            fwd_b_next = idx_rt + SEL_W'(1);
        end
    end

    // Youngest slot loads the issuing instruction or a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            track_reg[0] <= '0;
        end else begin
            track_reg[0] <= entry_next;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_track
            // Older slots shift down the pipe each cycle.
            always_ff @(posedge clk) begin
                if (reset) begin
                    track_reg[gi] <= '0;
                end else begin
                    track_reg[gi] <= track_reg[gi-1];
                end
            end
        end
    endgenerate

    // Forward selects and saturating stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_a_reg     <= '0;
            fwd_b_reg     <= '0;
            stall_cnt_reg <= '0;
        end else begin
            fwd_a_reg <= fwd_a_next;
            fwd_b_reg <= fwd_b_next;
            if (stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign bus.stall     = stall;
    assign bus.ex_fwd_a  = fwd_a_reg;
    assign bus.ex_fwd_b  = fwd_b_reg;
    assign bus.stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed scenarios for the pipeline hazard scoreboard, default parameters.
module tb_pipe_hazard_scoreboard;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    pipe_hazard_scoreboard_if #(.REG_AW(5), .SEL_W(2), .CNT_W(16)) bus ();

    pipe_hazard_scoreboard #(
        .DEPTH(4), .REG_AW(5), .ALU_RDY(1), .LD_RDY(3), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic wr,
                          input logic [4:0] rd, input logic ld);
        bus.id_valid  = v;
        bus.id_rs     = rs;
        bus.id_rt     = rt;
        bus.id_use_rs = urs;
        bus.id_use_rt = urt;
        bus.id_wr     = wr;
        bus.id_rd     = rd;
        bus.id_load   = ld;
        bus.flush     = 1'b0;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        nop();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %0b want 0", bus.stall); else passed++;
        checks++; if (bus.ex_fwd_a !== 2'd0) $display("FAIL reset_fwd_a: got %0d want 0", bus.ex_fwd_a); else passed++;
        checks++; if (bus.ex_fwd_b !== 2'd0) $display("FAIL reset_fwd_b: got %0d want 0", bus.ex_fwd_b); else passed++;
        checks++; if (bus.stall_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", bus.stall_cnt); else passed++;
        $display("txn reset done");
    endtask

    // add r3 then add r4,r3,r1: EX/EX forward on operand A.
    task automatic test_alu_fwd();
        do_reset();
        set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0);
        checks++; if (bus.stall !== 1'b0) $display("FAIL alu_prod_stall: got %0b want 0", bus.stall); else passed++;
        tick();
        set_id(1, 5'd3, 5'd1, 1, 1, 1, 5'd4, 0);
        checks++; if (bus.stall !== 1'b0) $display("FAIL alu_cons_stall: got %0b want 0", bus.stall); else passed++;
        tick();
        checks++; if (bus.ex_fwd_a !== 2'd1) $display("FAIL alu_fwd_a: got %0d want 1", bus.ex_fwd_a); else passed++;
        checks++; if (bus.ex_fwd_b !== 2'd0) $display("FAIL alu_fwd_b: got %0d want 0", bus.ex_fwd_b); else passed++;
        $display("txn alu_fwd fwd_a=%0d fwd_b=%0d", bus.ex_fwd_a, bus.ex_fwd_b);
    endtask

    // lw r5 then consumer of r5 on rt: two stall cycles, then MEM/WB forward.
    task automatic test_load_use();
        do_reset();
        set_id(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1);
        tick();
        set_id(1, 5'd2, 5'd5, 1, 1, 1, 5'd6, 0);
        checks++; if (bus.stall !== 1'b1) $display("FAIL lu_stall1: got %0b want 1", bus.stall); else passed++;
        tick();
        checks++; if (bus.stall !== 1'b1) $display("FAIL lu_stall2: got %0b want 1", bus.stall); else passed++;
        checks++; if (bus.ex_fwd_b !== 2'd0) $display("FAIL lu_bubble_fwd: got %0d want 0", bus.ex_fwd_b); else passed++;
        tick();
        checks++; if (bus.stall !== 1'b0) $display("FAIL lu_release: got %0b want 0", bus.stall); else passed++;
        tick();
        checks++; if (bus.ex_fwd_b !== 2'd3) $display("FAIL lu_fwd_b: got %0d want 3", bus.ex_fwd_b); else passed++;
        checks++; if (bus.ex_fwd_a !== 2'd0) $display("FAIL lu_fwd_a: got %0d want 0", bus.ex_fwd_a); else passed++;
        checks++; if (bus.stall_cnt !== 16'd2) $display("FAIL lu_cnt: got %0d want 2", bus.stall_cnt); else passed++;
        $display("txn load_use fwd_b=%0d stall_cnt=%0d", bus.ex_fwd_b, bus.stall_cnt);
    endtask

    // Producer, d-1 independent ops, then consumer of rs: count stalls and check select.
    task automatic test_distance();
        int n;
        int exp_stalls;
        int exp_fwd;
        for (int ld = 0; ld < 2; ld++) begin
            for (int d = 1; d <= 4; d++) begin
                do_reset();
                set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd9, ld[0]);
                tick();
                for (int i = 1; i < d; i++) begin
                    set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd10, 0);
                    tick();
                end
                set_id(1, 5'd9, 5'd2, 1, 1, 1, 5'd11, 0);
                n = 0;
                while (bus.stall === 1'b1 && n < 6) begin
                    n++;
                    tick();
                end
                tick();
                exp_stalls = (ld != 0 && d < 3) ? 3 - d : 0;
                exp_fwd    = (d <= 3) ? ((ld != 0) ? 3 : d) : 0;
                checks++; if (n != exp_stalls) $display("FAIL dist_stalls ld=%0d d=%0d: got %0d want %0d", ld, d, n, exp_stalls); else passed++;
                checks++; if (bus.ex_fwd_a !== 2'(exp_fwd)) $display("FAIL dist_fwd ld=%0d d=%0d: got %0d want %0d", ld, d, bus.ex_fwd_a, exp_fwd); else passed++;
                $display("txn distance ld=%0d d=%0d stalls=%0d fwd_a=%0d", ld, d, n, bus.ex_fwd_a);
            end
        end
    endtask

    // r0 is never a hazard; same register on both operands gets identical selects.
    task automatic test_r0_and_same();
        do_reset();
        set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd0, 0);
        tick();
        set_id(1, 5'd0, 5'd0, 1, 1, 1, 5'd4, 0);
        checks++; if (bus.stall !== 1'b0) $display("FAIL r0_stall: got %0b want 0", bus.stall); else passed++;
        tick();
        checks++; if (bus.ex_fwd_a !== 2'd0) $display("FAIL r0_fwd_a: got %0d want 0", bus.ex_fwd_a); else passed++;
        checks++; if (bus.ex_fwd_b !== 2'd0) $display("FAIL r0_fwd_b: got %0d want 0", bus.ex_fwd_b); else passed++;
        $display("txn r0 fwd_a=%0d fwd_b=%0d", bus.ex_fwd_a, bus.ex_fwd_b);
        // r4 was produced by the previous op (now in EX); read it on both operands.
        set_id(1, 5'd4, 5'd4, 1, 1, 1, 5'd6, 0);
        tick();
        checks++; if (bus.ex_fwd_a !== 2'd1) $display("FAIL same_fwd_a: got %0d want 1", bus.ex_fwd_a); else passed++;
        checks++; if (bus.ex_fwd_b !== 2'd1) $display("FAIL same_fwd_b: got %0d want 1", bus.ex_fwd_b); else passed++;
        // Load to r7, consumer reads r7 only through rt: the rt hazard alone stalls.
        set_id(1, 5'd1, 5'd0, 1, 0, 1, 5'd7, 1);
        tick();
        set_id(1, 5'd7, 5'd7, 0, 1, 1, 5'd8, 0);
        checks++; if (bus.stall !== 1'b1) $display("FAIL same_rt_only_stall: got %0b want 1", bus.stall); else passed++;
        $display("txn same_operand fwd=%0d stall=%0b", bus.ex_fwd_b, bus.stall);
    endtask

    // add r7, lw r7, use r7: the younger load governs.
    task automatic test_back_to_back();
        do_reset();
        set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd7, 0);
        tick();
        set_id(1, 5'd1, 5'd0, 1, 0, 1, 5'd7, 1);
        checks++; if (bus.stall !== 1'b0) $display("FAIL b2b_lw_stall: got %0b want 0", bus.stall); else passed++;
        tick();
        set_id(1, 5'd7, 5'd2, 1, 1, 1, 5'd8, 0);
        checks++; if (bus.stall !== 1'b1) $display("FAIL b2b_stall1: got %0b want 1", bus.stall); else passed++;
        tick();
        checks++; if (bus.stall !== 1'b1) $display("FAIL b2b_stall2: got %0b want 1", bus.stall); else passed++;
        tick();
        checks++; if (bus.stall !== 1'b0) $display("FAIL b2b_release: got %0b want 0", bus.stall); else passed++;
        tick();
        checks++; if (bus.ex_fwd_a !== 2'd3) $display("FAIL b2b_fwd_a: got %0d want 3", bus.ex_fwd_a); else passed++;
        checks++; if (bus.stall_cnt !== 16'd2) $display("FAIL b2b_cnt: got %0d want 2", bus.stall_cnt); else passed++;
        $display("txn back_to_back fwd_a=%0d stall_cnt=%0d", bus.ex_fwd_a, bus.stall_cnt);
    endtask

    // Flush beats stall; then reset in the middle of a stall clears everything.
    task automatic test_flush_reset();
        do_reset();
        set_id(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1);
        tick();
        set_id(1, 5'd2, 5'd5, 1, 1, 1, 5'd6, 0);
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b0) $display("FAIL flush_stall: got %0b want 0", bus.stall); else passed++;
        tick();
        checks++; if (bus.ex_fwd_b !== 2'd0) $display("FAIL flush_fwd_b: got %0d want 0", bus.ex_fwd_b); else passed++;
        checks++; if (bus.stall_cnt !== 16'd0) $display("FAIL flush_cnt: got %0d want 0", bus.stall_cnt); else passed++;
        bus.flush = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b1) $display("FAIL pre_reset_stall: got %0b want 1", bus.stall); else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) $display("FAIL midreset_stall: got %0b want 0", bus.stall); else passed++;
        checks++; if (bus.stall_cnt !== 16'd0) $display("FAIL midreset_cnt: got %0d want 0", bus.stall_cnt); else passed++;
        checks++; if (bus.ex_fwd_a !== 2'd0) $display("FAIL midreset_fwd_a: got %0d want 0", bus.ex_fwd_a); else passed++;
        tick();
        checks++; if (bus.ex_fwd_b !== 2'd0) $display("FAIL midreset_fwd_b: got %0d want 0", bus.ex_fwd_b); else passed++;
        $display("txn flush_reset stall=%0b fwd_b=%0d", bus.stall, bus.ex_fwd_b);
    endtask

    initial begin
        nop();
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_distance();
        test_r0_and_same();
        test_back_to_back();
        test_flush_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
